// File: rtl/lsu_mem_if.sv
// Load/store unit: byte-lane steering, load extension and fault checks in the
// accept cycle, with a single registered response slot.
module lsu_mem_if #(
  parameter int ADDR_LIMIT = 65536,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_fault,
  output logic [31:0]      dmem_wr_addr,
  output logic [31:0]      dmem_wr_data,
  output logic [3:0]       dmem_wr_en,
  output logic [31:0]      dmem_rd_addr,
  input  logic [31:0]      dmem_rd_data,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  logic        accept;
  logic        f3_ok;
  logic        misalign;
  logic        out_of_range;
  logic        fault;
  logic [1:0]  off;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] word_sh;
  logic [31:0] ld_data;

  assign req_ready = !rst && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[1:0];

  always_comb begin
    f3_ok = 1'b0;
    if (req_we)
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    else
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
              (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
  end

  // funct3[1:0] encodes access size for every legal load and store
  assign misalign     = ((req_funct3[1:0] == 2'd1) && off[0]) ||
                        ((req_funct3[1:0] == 2'd2) && (off != 2'd0));
  assign out_of_range = (req_addr >= LIMIT);
  assign fault        = !f3_ok || misalign || out_of_range;

  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (req_funct3[1:0])
      2'd0: begin
        st_mask = 4'b0001 << off;
        st_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_mask = 4'b0011 << off;
        st_data = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        st_mask = 4'b1111;
        st_data = req_wdata;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  assign dmem_wr_addr = {req_addr[31:2], 2'b00};
  assign dmem_wr_data = st_data;
  assign dmem_wr_en   = (accept && req_we && !fault) ? st_mask : 4'b0000;
  assign dmem_rd_addr = {req_addr[31:2], 2'b00};

  assign word_sh = dmem_rd_data >> {off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (req_funct3)
      3'd0:    ld_data = {{24{word_sh[7]}}, word_sh[7:0]};
      3'd1:    ld_data = {{16{word_sh[15]}}, word_sh[15:0]};
      3'd2:    ld_data = dmem_rd_data;
      3'd4:    ld_data = {24'h0, word_sh[7:0]};
      3'd5:    ld_data = {16'h0, word_sh[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      load_cnt   <= '0;
      store_cnt  <= '0;
      fault_cnt  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_fault <= fault;
      resp_rdata <= (fault || req_we) ? 32'h0 : ld_data;
      if (fault)
        fault_cnt <= fault_cnt + CNT_W'(1);
      else if (req_we)
        store_cnt <= store_cnt + CNT_W'(1);
      else
        load_cnt  <= load_cnt + CNT_W'(1);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
